sba_rr_arbiter: RTL
===================

# sba_rr_arbiter

Round-robin arbiter that shares the single system-bus memory port between several bus masters: the debug module's system-bus access, the boot/ELF loader and the DMA. Each upstream master uses an OBI-style req/gnt/rvalid handshake. The block picks one winner per transfer and holds the downstream request stable until it is granted. It records the winner's index in an in-order ID FIFO and routes each response back to the master that issued it.

## Interface
Parameters:
- NumReq, 3, number of upstream requesters (2..8)
- AddrWidth, 32, address width
- DataWidth, 32, data width; byte-enable width is DataWidth/8
- MaxTrans, 4, maximum outstanding transfers downstream (ID FIFO depth, power of two, ≥2)

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NumReq  per-requester request
- gnt_o  out  NumReq  per-requester grant (one-hot or zero)
- addr_i  in  NumReq×AddrWidth  per-requester address
- we_i  in  NumReq  per-requester write enable
- be_i  in  NumReq×DataWidth/8  per-requester byte enables
- wdata_i  in  NumReq×DataWidth  per-requester write data
- rvalid_o  out  NumReq  per-requester response valid (one-hot or zero)
- rdata_o  out  DataWidth  response data, broadcast to all requesters
- err_o  out  1  response error, qualified by rvalid_o
- mem_req_o  out  1  downstream request
- mem_gnt_i  in  1  downstream grant
- mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o  out  per widths above  downstream command
- mem_rvalid_i  in  1  downstream response valid
- mem_rdata_i  in  DataWidth  downstream read data
- mem_err_i  in  1  downstream error
- outstanding_o  out  $clog2(MaxTrans+1)  transfers in flight
- unexp_rsp_o  out  1  sticky flag: response received with no transfer outstanding

## Operation
- Two-state FSM per command slot:
  - ARB: winner = first asserted req_i searching from rr_ptr_q upward, with wrap-around.
  - HOLD: the winner is locked in winner_q.
- Issue condition: mem_req_o = (ARB ? |req_i : 1) & (count_q < MaxTrans). The command mux selects the current or locked winner.
- ARB, mem_req_o high, mem_gnt_i high: handshake done. gnt_o[winner]=1, push winner into the ID FIFO, rr_ptr_q ← winner+1 mod NumReq. Stay in ARB.
- ARB, mem_req_o high, mem_gnt_i low: winner_q ← winner, go to HOLD. The downstream command must stay stable until grant (OBI rule), so arbitration is frozen.
- HOLD: present winner_q's command. On mem_gnt_i: grant, push, update rr_ptr_q, return to ARB.
- HOLD, count_q reaches MaxTrans: mem_req_o drops. The OBI stability rule does not apply to a withdrawn request, and HOLD is kept so the same winner reissues.
- Upstream masters must hold req_i and the command until gnt_o. A master that drops req_i while in HOLD is an upstream protocol violation and is not handled.
- Responses are in order. On mem_rvalid_i with the FIFO non-empty:
  - rvalid_o[head]=1, rdata_o=mem_rdata_i, err_o=mem_err_i, pop the FIFO.
- mem_rvalid_i with the FIFO empty: the response is dropped, unexp_rsp_o is set and stays set until reset.
- Push and pop in the same cycle: count_q is unchanged. Pointers wrap modulo MaxTrans.

## Timing
- Grant path is combinational: gnt_o and mem_req_o are asserted in the same cycle as req_i when the FIFO is not full. Zero added latency.
- Response path is combinational: rvalid_o/rdata_o/err_o are valid in the same cycle as mem_rvalid_i.
- Earliest response is one cycle after its grant. A same-cycle gnt+rvalid belongs to an earlier transfer.
- Full stall: while count_q == MaxTrans, mem_req_o=0 even if a pop happens that cycle. Issue resumes the cycle after count_q drops.
- Reset values: rr_ptr_q=0 (requester 0 has first priority), FSM=ARB, FIFO empty, count_q=0, unexp_rsp_o=0. All outputs derived from these are 0 while no req_i is asserted.
- Reset during operation: outstanding IDs are discarded. Late downstream responses after reset set unexp_rsp_o.

## Test plan
- Single requester 1 reads 0x0001_0000, memory grants immediately and answers 1 cycle later with 0xDEADBEEF → gnt_o=3'b010 in the same cycle; rvalid_o=3'b010 with rdata_o=0xDEADBEEF; outstanding_o returns to 0.
- All 3 requesters hold req continuously, mem_gnt_i=1 always, 6 transfers → grant order 0,1,2,0,1,2; responses routed in the same order.
- Requester 2 requests, mem_gnt_i low for 3 cycles while requester 0 also asserts → mem_addr_o stays at requester 2's address all 3 cycles; requester 2 granted first, then requester 0.
- MaxTrans=4, memory grants but withholds responses → after 4 grants mem_req_o=0 and outstanding_o=4; one rvalid → the next grant comes the following cycle.
- mem_rvalid_i pulsed with nothing outstanding → no rvalid_o asserted; unexp_rsp_o=1 and sticky until rst_ni low.
- Write with mem_err_i=1 on its response → rvalid_o asserted only for the issuing requester with err_o=1.

Source files
------------

// File: rtl/sba_rr_arbiter.sv
// Round-robin arbiter sharing one OBI memory port among several masters.
// Locks the winner until the downstream grant; routes in-order responses by an ID FIFO.
module sba_rr_arbiter #(
  parameter int unsigned NumReq    = 3,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxTrans  = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumReq-1:0]                     req_i,
  output logic [NumReq-1:0]                     gnt_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]      addr_i,
  input  logic [NumReq-1:0]                     we_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]    be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]      wdata_i,
  output logic [NumReq-1:0]                     rvalid_o,
  output logic [DataWidth-1:0]                  rdata_o,
  output logic                                  err_o,
  output logic                                  mem_req_o,
  input  logic                                  mem_gnt_i,
  output logic [AddrWidth-1:0]                  mem_addr_o,
  output logic                                  mem_we_o,
  output logic [DataWidth/8-1:0]                mem_be_o,
  output logic [DataWidth-1:0]                  mem_wdata_o,
  input  logic                                  mem_rvalid_i,
  input  logic [DataWidth-1:0]                  mem_rdata_i,
  input  logic                                  mem_err_i,
  output logic [$clog2(MaxTrans+1)-1:0]         outstanding_o,
  output logic                                  unexp_rsp_o
);

  localparam int unsigned IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = $clog2(MaxTrans);
  localparam int unsigned CntW = $clog2(MaxTrans+1);

  typedef enum logic {S_ARB, S_HOLD} state_e;

  state_e          r_state, w_state_nxt;
  logic [IdW-1:0]  r_rr_ptr, r_winner;
  logic [IdW-1:0]  w_idx_hi, w_idx_lo, w_arb_idx, w_sel;
  logic            w_found_hi, w_any_req, w_full, w_hs, w_push, w_pop;
  logic [IdW-1:0]  r_fifo [MaxTrans];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_count;

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    w_idx_hi   = '0;
    w_idx_lo   = '0;
    w_found_hi = 1'b0;
    for (int i = NumReq-1; i >= 0; i--) begin
      if (req_i[i]) begin
        w_idx_lo = IdW'(i);
        if (IdW'(i) >= r_rr_ptr) begin
          w_idx_hi   = IdW'(i);
          w_found_hi = 1'b1;
        end
      end
    end
    w_arb_idx = w_found_hi ? w_idx_hi : w_idx_lo;
  end

  assign w_any_req = |req_i;
  assign w_full    = (r_count == CntW'(MaxTrans));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_ARB;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ARB:   if (mem_req_o && !mem_gnt_i) w_state_nxt = S_HOLD;
      S_HOLD:  if (mem_req_o &&  mem_gnt_i) w_state_nxt = S_ARB;
      default: w_state_nxt = S_ARB;
    endcase
  end

  always_comb begin
    w_sel       = (r_state == S_HOLD) ? r_winner : w_arb_idx;
    mem_req_o   = ((r_state == S_HOLD) ? 1'b1 : w_any_req) & ~w_full;
    w_hs        = mem_req_o & mem_gnt_i;
    gnt_o       = w_hs ? (NumReq'(1) << w_sel) : '0;
    mem_addr_o  = addr_i[w_sel];
    mem_we_o    = we_i[w_sel];
    mem_be_o    = be_i[w_sel];
    mem_wdata_o = wdata_i[w_sel];
  end

  assign w_push = w_hs;
  assign w_pop  = mem_rvalid_i & (r_count != '0);

  assign rvalid_o      = w_pop ? (NumReq'(1) << r_fifo[r_rptr]) : '0;
  assign rdata_o       = mem_rdata_i;
  assign err_o         = w_pop & mem_err_i;
  assign outstanding_o = r_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr    <= '0;
      r_winner    <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      unexp_rsp_o <= 1'b0;
    end else begin
      if (r_state == S_ARB && mem_req_o && !mem_gnt_i) r_winner <= w_arb_idx;
      if (w_hs) r_rr_ptr <= (w_sel == IdW'(NumReq-1)) ? '0 : w_sel + 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (mem_rvalid_i && r_count == '0) unexp_rsp_o <= 1'b1;
    end
  end

  // ID storage needs no reset: entries are only read while counted as outstanding.
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wptr] <= w_sel;
  end

endmodule
